// File: rtl/pll_lock_monitor_pkg.sv
// Shared types and widths for the PLL lock monitor.
package pll_mon_pkg;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned LOSS_CNT_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        RUN       = 2'd2,
        RECOVER   = 2'd3
    } mon_state_e;

endpackage

// File: rtl/pll_lock_monitor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, clearing to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q;
    logic s2_d, s2_q;

    // Next-state of the two synchronizer stages.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchronizer stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies the PLL LOCK signal and generates the downstream reset/ready pair.
// Optional lock-loss counter enabled by defining PLL_MON_LOSS_CNT_EN.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned MIN_RST_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock,
    output logic                  sys_rst,
    output logic                  ready,
`ifdef PLL_MON_LOSS_CNT_EN
    output logic [LOSS_CNT_W-1:0] loss_cnt,
`endif
    output logic                  lock_lost
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(MIN_RST_CYCLES - 1);

    logic             lock_s;
    mon_state_e       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             sys_rst_d, sys_rst_q;
    logic             ready_d, ready_q;
    logic             lock_lost_d, lock_lost_q;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_lost_d = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = {CNT_W{1'b0}};
                if (lock_s) begin
                    state_d = QUALIFY;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            QUALIFY: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d     = RECOVER;
                    cnt_d       = {CNT_W{1'b0}};
                    lock_lost_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RECOVER: begin
                // Lock state is ignored here so a quick re-lock cannot shorten the reset.
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        ready_d   = (state_d == RUN);
        sys_rst_d = (state_d != RUN);
    end

    // FSM, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= {CNT_W{1'b0}};
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;

`ifdef PLL_MON_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_d, loss_cnt_q;

    // Saturating count of lock-loss events.
    always_comb begin
        if (lock_lost_d && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
        end else begin
            loss_cnt_d = loss_cnt_q;
        end
    end

    // Loss counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt_q <= {LOSS_CNT_W{1'b0}};
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed self-checking bench for pll_lock_monitor (STABLE_CYCLES=16, MIN_RST_CYCLES=8).
module tb_pll_lock_monitor;

    logic clk = 1'b0;
    logic rst;
    logic pll_lock;
    logic sys_rst;
    logic ready;
    logic lock_lost;
`ifdef PLL_MON_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_monitor #(
        .STABLE_CYCLES  (16),
        .MIN_RST_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .sys_rst   (sys_rst),
        .ready     (ready),
`ifdef PLL_MON_LOSS_CNT_EN
        .loss_cnt  (loss_cnt),
`endif
        .lock_lost (lock_lost)
    );

    always #5 clk = ~clk;

    // Inputs set before a tick are sampled at that edge; outputs read 1 time unit later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Edge 0 samples rst=1; the following edges are numbered 1, 2, ... from release.
    task automatic do_reset;
        rst      = 1'b1;
        pll_lock = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        pll_lock = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({sys_rst, ready, lock_lost} !== 3'b100) begin
            $display("FAIL reset: {sys_rst,ready,lock_lost}=%b expected 100", {sys_rst, ready, lock_lost});
            n_fail++;
        end
`ifdef PLL_MON_LOSS_CNT_EN
        n_tests++;
        if (loss_cnt !== 8'd0) begin
            $display("FAIL reset_loss_cnt: got %0d expected 0", loss_cnt);
            n_fail++;
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_no_lock;
        do_reset();
        for (int e = 1; e <= 200; e++) begin
            pll_lock = 1'b0;
            tick();
            n_tests++;
            if ({sys_rst, ready, lock_lost} !== 3'b100) begin
                $display("FAIL no_lock edge %0d: got %b expected 100", e, {sys_rst, ready, lock_lost});
                n_fail++;
            end
        end
    endtask

    task automatic test_lock_qualify;
        logic r;
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            pll_lock = (e >= 10);
            tick();
            r = (e >= 28);
            n_tests++;
            if ({sys_rst, ready, lock_lost} !== {~r, r, 1'b0}) begin
                $display("FAIL qualify edge %0d: got %b expected %b", e, {sys_rst, ready, lock_lost}, {~r, r, 1'b0});
                n_fail++;
            end
        end
    endtask

    task automatic test_glitch;
        logic r;
        do_reset();
        for (int e = 1; e <= 50; e++) begin
            pll_lock = ((e >= 5) && (e <= 14)) || (e >= 16);
            tick();
            r = (e >= 34);
            n_tests++;
            if ({sys_rst, ready, lock_lost} !== {~r, r, 1'b0}) begin
                $display("FAIL glitch edge %0d: got %b expected %b", e, {sys_rst, ready, lock_lost}, {~r, r, 1'b0});
                n_fail++;
            end
        end
    endtask

    // Lock drops for one sample at edge 26 and returns at 27: RECOVER must still last 8 cycles.
    task automatic test_loss_recover;
        logic r;
        logic ll;
        do_reset();
        for (int e = 1; e <= 70; e++) begin
            pll_lock = (e != 26);
            tick();
            r  = ((e >= 19) && (e <= 27)) || (e >= 53);
            ll = (e == 28);
            n_tests++;
            if ({sys_rst, ready, lock_lost} !== {~r, r, ll}) begin
                $display("FAIL loss_recover edge %0d: got %b expected %b", e, {sys_rst, ready, lock_lost}, {~r, r, ll});
                n_fail++;
            end
        end
    endtask

    // Reset pulse during RUN at edge 24: requalification from a cleared synchronizer.
    task automatic test_rst_mid_run;
        logic r;
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            rst      = (e == 24);
            pll_lock = 1'b1;
            tick();
            r = ((e >= 19) && (e < 24)) || (e >= 43);
            n_tests++;
            if ({sys_rst, ready, lock_lost} !== {~r, r, 1'b0}) begin
                $display("FAIL rst_mid_run edge %0d: got %b expected %b", e, {sys_rst, ready, lock_lost}, {~r, r, 1'b0});
                n_fail++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_rst_mid_qualify;
        logic r;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            rst      = (e == 10);
            pll_lock = 1'b1;
            tick();
            r = (e >= 29);
            n_tests++;
            if ({sys_rst, ready, lock_lost} !== {~r, r, 1'b0}) begin
                $display("FAIL rst_mid_qualify edge %0d: got %b expected %b", e, {sys_rst, ready, lock_lost}, {~r, r, 1'b0});
                n_fail++;
            end
        end
        rst = 1'b0;
    endtask

    // Lock lost at edge 24 (RECOVER), reset at edge 27 while still recovering.
    task automatic test_rst_mid_recover;
        logic r;
        logic ll;
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            rst      = (e == 27);
            pll_lock = (e <= 21) || (e >= 28);
            tick();
            r  = ((e >= 19) && (e <= 23)) || (e >= 46);
            ll = (e == 24);
            n_tests++;
            if ({sys_rst, ready, lock_lost} !== {~r, r, ll}) begin
                $display("FAIL rst_mid_recover edge %0d: got %b expected %b", e, {sys_rst, ready, lock_lost}, {~r, r, ll});
                n_fail++;
            end
        end
        rst = 1'b0;
    endtask

`ifdef PLL_MON_LOSS_CNT_EN
    task automatic test_loss_cnt;
        int budget;
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            pll_lock = 1'b1;
            budget   = 0;
            while (!ready && budget < 100) begin
                tick();
                budget++;
            end
            pll_lock = 1'b0;
            while (!lock_lost && budget < 200) begin
                tick();
                budget++;
            end
            if (budget >= 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL loss_cnt_timeout event %0d: got no lock_lost expected pulse", k);
                break;
            end
            if (k == 1) begin
                n_tests++;
                if (loss_cnt !== 8'd1) begin
                    $display("FAIL loss_cnt_first: got %0d expected 1", loss_cnt);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (loss_cnt !== 8'd255) begin
            $display("FAIL loss_cnt_sat: got %0d expected 255", loss_cnt);
            n_fail++;
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        pll_lock = 1'b0;
        test_reset();
        test_no_lock();
        test_lock_qualify();
        test_glitch();
        test_loss_recover();
        test_rst_mid_run();
        test_rst_mid_qualify();
        test_rst_mid_recover();
`ifdef PLL_MON_LOSS_CNT_EN
        test_loss_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
